// File: rtl/alu_mul_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_mul_seq
//  Description : Sequential shift-and-add 32x32 multiplier (low 32 bits of the
//                product) that borrows a shared external ALU for every add and
//                shift, scanning the multiplier from its LSB upward.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_mul_seq #(
    parameter logic [2:0] OP_ADD = 3'b010,
    parameter logic [2:0] OP_SLL = 3'b101
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        ready,
    output logic        done,
    output logic [31:0] product,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_op,
    output logic [4:0]  alu_sa,
    input  logic [31:0] alu_res
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ADD   = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]  r_state;
    logic [1:0]  w_next_state;
    logic [31:0] r_p;
    logic [31:0] r_m;
    logic [31:0] r_q;
    logic [31:0] r_product;
    logic [31:0] w_q_shr;

    // Multiplier after the shift that the current SHIFT cycle performs.
    assign w_q_shr = {1'b0, r_q[31:1]};
    assign product = r_product;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode and ALU drive; the ALU sits parked on a zero add
    // whenever its result is not being consumed.
    always_comb begin
        w_next_state = r_state;
        ready        = 1'b0;
        done         = 1'b0;
        alu_a        = 32'd0;
        alu_b        = 32'd0;
        alu_op       = OP_ADD;
        alu_sa       = 5'd0;
        case (r_state)
            S_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    if (op_b == 32'd0) begin
                        w_next_state = S_DONE;
                    end else if (op_b[0]) begin
                        w_next_state = S_ADD;
                    end else begin
                        w_next_state = S_SHIFT;
                    end
                end
            end
            S_ADD: begin
                alu_a        = r_p;
                alu_b        = r_m;
                alu_op       = OP_ADD;
                w_next_state = S_SHIFT;
            end
            S_SHIFT: begin
                alu_b  = r_m;
                alu_op = OP_SLL;
                alu_sa = 5'd1;
                // Stop as soon as no set multiplier bits remain.
                if (w_q_shr == 32'd0) begin
                    w_next_state = S_DONE;
                end else if (r_q[1]) begin
                    w_next_state = S_ADD;
                end else begin
                    w_next_state = S_SHIFT;
                end
            end
            S_DONE: begin
                done         = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Datapath registers: load on accept, accumulate in ADD, shift in SHIFT,
    // publish the accumulator when heading into DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_p       <= 32'd0;
            r_m       <= 32'd0;
            r_q       <= 32'd0;
            r_product <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_p       <= 32'd0;
                        r_m       <= op_a;
                        r_q       <= op_b;
                        r_product <= 32'd0;
                    end
                end
                S_ADD: begin
                    r_p <= alu_res;
                end
                S_SHIFT: begin
                    r_m <= alu_res;
                    r_q <= w_q_shr;
                    if (w_q_shr == 32'd0) begin
                        r_product <= r_p;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/alu_mul_seq.md
ALU_MUL_SEQ -- requirements
Module: alu_mul_seq

Interface
REQ-001 Parameter OP_ADD, default 3'b010, SHALL be the alu op code for A+B.
REQ-002 Parameter OP_SLL, default 3'b101, SHALL be the alu op code for B shifted left by sa.
REQ-003 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  SHALL be a synchronous, active-high reset.
REQ-005 Port start  input  1  SHALL request a multiply; sampled only when ready=1.
REQ-006 Port op_a  input  32  SHALL be the multiplicand, sampled with start.
REQ-007 Port op_b  input  32  SHALL be the multiplier, sampled with start.
REQ-008 Port ready  output  1  SHALL be 1 exactly while in IDLE.
REQ-009 Port done  output  1  SHALL pulse 1 for one cycle when product is valid.
REQ-010 Port product  output  32  SHALL hold the low 32 bits of op_a*op_b from done until the next accepted start.
REQ-011 Ports alu_a, alu_b  output  32, alu_op  output  3, alu_sa  output  5  SHALL drive the shared alu.
REQ-012 Port alu_res  input  32  SHALL be the combinational alu result for the current drive values.

Function
REQ-013 Internal registers: P (accumulator), M (multiplicand), Q (multiplier), all 32 bits.
REQ-014 States SHALL be IDLE, ADD, SHIFT, DONE.
REQ-015 IDLE and start=1: P<=0, M<=op_a, Q<=op_b, product<=0; next state ADD if op_b[0]=1, SHIFT if op_b!=0 and op_b[0]=0, DONE if op_b=0.
REQ-016 IDLE and start=0: state and registers SHALL be unchanged.
REQ-017 ADD drive: alu_a=P, alu_b=M, alu_op=OP_ADD, alu_sa=0; at edge P<=alu_res; next state SHIFT.
REQ-018 SHIFT drive: alu_a=0, alu_b=M, alu_op=OP_SLL, alu_sa=1; at edge M<=alu_res and Q<=Q>>1 (logical, internal).
REQ-019 SHIFT next state: DONE if (Q>>1)=0; else ADD if Q[1]=1; else SHIFT.
REQ-020 DONE: done=1, product<=P at entry to DONE is visible in the same cycle (product driven from P); next state IDLE unconditionally.
REQ-021 In IDLE and DONE, alu_a, alu_b, alu_sa SHALL be 0 and alu_op SHALL be OP_ADD.
REQ-022 start while not in IDLE SHALL be ignored; no queuing.
REQ-023 Overflow above bit 31 SHALL be discarded silently (add and shift wrap modulo 2^32); result is correct for signed and unsigned two's-complement operands.
REQ-024 Latency from accepting edge to done cycle SHALL be popcount(op_b) + (index of highest set bit of op_b + 1) + 1 cycles; op_b=0 gives done in the cycle immediately after the accepting edge.
REQ-025 Maximum latency (op_b=32'hFFFF_FFFF) SHALL be 65 cycles; no counter overflow possible.
REQ-026 product SHALL update only on entry to DONE and on reset/accepted start (cleared to 0).
REQ-027 alu_res SHALL be ignored in IDLE and DONE.

Reset
REQ-028 rst=1 at a rising edge SHALL force state IDLE, P=M=Q=0, product=0, done=0, ready=1 regardless of current state, including mid-multiply.
REQ-029 start asserted in the same cycle as rst SHALL be ignored.
REQ-030 First multiply after reset release SHALL behave identically to any other.

Verification (bench instantiates the team alu on the alu_* ports)
REQ-031 op_a=3, op_b=5, start one cycle -> state sequence ADD,SHIFT,SHIFT,ADD,SHIFT,DONE; done in 6th cycle after accept; product=15.
REQ-032 op_a=32'h1234_5678, op_b=0 -> done in 1st cycle after accept, product=0, no ADD/SHIFT cycles on alu_op.
REQ-033 op_a=op_b=32'hFFFF_FFFF -> done at cycle 65, product=32'h0000_0001; op_a=32'h8000_0000, op_b=2 -> product=0 (wrap).
REQ-034 op_a=-7 (32'hFFFF_FFF9), op_b=6 -> product=32'hFFFF_FFD6 (-42); start pulsed again mid-operation -> ignored, single done.
REQ-035 rst asserted 3 cycles into op_a=9, op_b=9 -> next cycle ready=1, product=0, no done; subsequent op_a=4, op_b=4 -> product=16.
REQ-036 Random 1000 operand pairs vs. reference model -> product equals (op_a*op_b) mod 2^32 and latency matches REQ-024 every time.
